// File: rtl/ps2_arrow_keys_if.sv
// PS/2 pin inputs and decoded arrow-key / debug byte outputs as one bundle.
// Pure wiring, no latency of its own.
// No backpressure: the pins free-run and the outputs are level/pulse signals.
interface ps2_arrow_keys_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] keyboard_keys;
    logic       byte_valid;
    logic [7:0] scan_byte;
    logic       frame_error;

    // Side that drives the PS/2 pins and observes the decoded outputs
    modport master (
        output ps2_clk,
        output ps2_data,
        input  keyboard_keys,
        input  byte_valid,
        input  scan_byte,
        input  frame_error
    );

    // The receiver/decoder itself
    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keyboard_keys,
        output byte_valid,
        output scan_byte,
        output frame_error
    );
endinterface

// File: rtl/ps2_arrow_keys.sv
// PS/2 frame receiver plus E0-prefixed arrow make/break decoder driving a held-key vector.
// Latency: pin edge to flagged edge 2-3 clk; byte_valid/frame_error at N+1, keyboard_keys at N+2.
// No backpressure: the keyboard cannot be stalled, every frame is consumed as it arrives.
module ps2_arrow_keys #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          reset,
    ps2_arrow_keys_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] C_E0    = 8'hE0;
    localparam logic [7:0] C_F0    = 8'hF0;
    localparam logic [7:0] C_UP    = 8'h75;
    localparam logic [7:0] C_DOWN  = 8'h72;
    localparam logic [7:0] C_RIGHT = 8'h74;
    localparam logic [7:0] C_LEFT  = 8'h6B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0_F0
    } state_t;

    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_clk_d;
    logic          r_dat_s1;
    logic          r_dat_s2;

    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_frame;
    logic [TW-1:0] r_to_cnt;
    logic          r_byte_valid;
    logic          r_frame_error;
    logic [7:0]    r_scan_byte;

    state_t        r_state;
    logic [3:0]    r_keys;

    logic          w_fall;
    logic          w_frame_ok;
    logic [3:0]    w_mask;

    // Falling edge of the synchronized PS/2 clock; data is sampled in this cycle
    assign w_fall = r_clk_d & ~r_clk_s2;

    // Start bit low, odd parity over data+parity, stop bit (the sample being taken now) high
    assign w_frame_ok = ~r_frame[0] & (^r_frame[9:1]) & r_dat_s2;

    // Arrow code to key-vector bit; non-arrow bytes map to an empty mask
    always_comb begin
        w_mask = 4'b0000;
        case (r_scan_byte)
            C_UP:    w_mask = 4'b0001;
            C_DOWN:  w_mask = 4'b0010;
            C_RIGHT: w_mask = 4'b0100;
            C_LEFT:  w_mask = 4'b1000;
            default: w_mask = 4'b0000;
        endcase
    end

    // Two-flop synchronizers on both pins plus the delayed clock for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b0;
            r_clk_s2 <= 1'b0;
            r_clk_d  <= 1'b0;
            r_dat_s1 <= 1'b0;
            r_dat_s2 <= 1'b0;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Frame receiver: shift in 11 bits, check on the stop bit, drop stalled partial frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt     <= 4'd0;
            r_frame       <= 10'd0;
            r_to_cnt      <= '0;
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_scan_byte   <= 8'h00;
        end else begin
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_scan_byte  <= r_frame[8:1];
                        r_byte_valid <= 1'b1;
                    end else begin
                        r_frame_error <= 1'b1;
                    end
                end else begin
                    r_frame[r_bit_cnt] <= r_dat_s2;
                    r_bit_cnt          <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                // A keyboard that stops mid-frame must not misalign the next frame
                if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_bit_cnt <= 4'd0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Make/break decoder: only E0-prefixed arrow codes touch the key vector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_keys  <= 4'b0000;
        end else if (r_frame_error) begin
            // A corrupted byte poisons whatever sequence was in flight
            r_state <= S_IDLE;
        end else if (r_byte_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (r_scan_byte == C_E0)      r_state <= S_E0;
                    else if (r_scan_byte == C_F0) r_state <= S_F0;
                    else                          r_state <= S_IDLE;
                end
                S_E0: begin
                    if (r_scan_byte == C_F0) begin
                        r_state <= S_E0_F0;
                    end else begin
                        r_keys  <= r_keys | w_mask;
                        r_state <= S_IDLE;
                    end
                end
                S_E0_F0: begin
                    r_keys  <= r_keys & ~w_mask;
                    r_state <= S_IDLE;
                end
                S_F0: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.keyboard_keys = r_keys;
    assign bus.byte_valid    = r_byte_valid;
    assign bus.scan_byte     = r_scan_byte;
    assign bus.frame_error   = r_frame_error;

endmodule

// File: tb/tb_ps2_arrow_keys.sv
// Bench for ps2_arrow_keys: vector table, hand-written timing/timeout/reset sequences,
// and randomized frames checked against a byte-sequence reference model.
module tb_ps2_arrow_keys;

    localparam int TO = 400;   // timeout override keeps the idle hold short
    localparam int H  = 10;    // PS/2 half-period in clk cycles

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_arrow_keys_if bus();

    ps2_arrow_keys #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q[$];
    int         err_seen;
    logic       prev_bv;
    logic       prev_fe;

    // Pulse monitor: collects good bytes and errors, enforces 1-cycle exclusive pulses
    always @(negedge clk) begin
        if (reset) begin
            prev_bv = 1'b0;
            prev_fe = 1'b0;
        end else begin
            if (bus.byte_valid || bus.frame_error) begin
                total++;
                if ((bus.byte_valid && bus.frame_error) || (bus.byte_valid && prev_bv) ||
                    (bus.frame_error && prev_fe)) begin
                    bad++;
                    $display("FAIL pulse_rule bv=%0b fe=%0b prev_bv=%0b prev_fe=%0b want single exclusive pulses",
                             bus.byte_valid, bus.frame_error, prev_bv, prev_fe);
                end
            end
            if (bus.byte_valid) got_q.push_back(bus.scan_byte);
            if (bus.frame_error) err_seen++;
            prev_bv = bus.byte_valid;
            prev_fe = bus.frame_error;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // fault: 0 none, 1 parity inverted, 2 start bit high, 3 stop bit low
    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic [1:0] fault);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = b;
        f[9]    = ~(^b);
        f[10]   = 1'b1;
        if (fault == 2'd1) f[9]  = ~f[9];
        if (fault == 2'd2) f[0]  = 1'b1;
        if (fault == 2'd3) f[10] = 1'b0;
        return f;
    endfunction

    // Drives nbits bits; returns right after the last falling edge with ps2_clk still low
    task automatic drive_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            wait_cyc(H);
            bus.ps2_clk = 1'b0;
            if (i != nbits - 1) begin
                wait_cyc(H);
                bus.ps2_clk = 1'b1;
            end
        end
    endtask

    task automatic release_line();
        wait_cyc(H);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(2 * H);
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] fault);
        drive_bits(make_frame(b, fault), 11);
        release_line();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(5);
    endtask

    typedef struct packed {
        logic [7:0] dat;
        logic [1:0] fault;
        logic [3:0] keys;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] d, input logic [1:0] f, input logic [3:0] k);
        vec_t v;
        v.dat = d; v.fault = f; v.keys = k;
        tbl.push_back(v);
    endtask

    // Reference model: keeps the bytes of the sequence in flight and interprets whole sequences
    logic [7:0] pq[$];
    logic [3:0] mkeys;

    function automatic int arrow_idx(input logic [7:0] b);
        case (b)
            8'h75: return 0;
            8'h72: return 1;
            8'h74: return 2;
            8'h6B: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int a;
        pq.push_back(b);
        if (pq[0] == 8'hE0) begin
            if (pq.size() == 2 && pq[1] != 8'hF0) begin
                a = arrow_idx(pq[1]);
                if (a >= 0) mkeys[a] = 1'b1;
                pq.delete();
            end else if (pq.size() == 3) begin
                a = arrow_idx(pq[2]);
                if (a >= 0) mkeys[a] = 1'b0;
                pq.delete();
            end
        end else if (pq[0] == 8'hF0) begin
            if (pq.size() == 2) pq.delete();
        end else begin
            pq.delete();
        end
    endtask

    logic [7:0] pool [0:10];
    logic [7:0] last_good;

    initial begin
        pool = '{8'hE0, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h72, 8'h74, 8'h6B, 8'h12, 8'hAA};

        // ---------------- reset state ----------------
        reset        = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        err_seen     = 0;
        wait_cyc(4);
        check("rst_keys",  32'(bus.keyboard_keys), 32'h0);
        check("rst_bv",    32'(bus.byte_valid),    32'h0);
        check("rst_fe",    32'(bus.frame_error),   32'h0);
        check("rst_scan",  32'(bus.scan_byte),     32'h0);
        reset = 1'b0;
        wait_cyc(5);

        // ---------------- press up with exact latency ----------------
        got_q.delete();
        send(8'hE0, 2'd0);
        drive_bits(make_frame(8'h75, 2'd0), 11);
        wait_cyc(3);
        check("lat_bv_n1",   32'(bus.byte_valid),    32'h1);
        check("lat_scan_n1", 32'(bus.scan_byte),     32'h75);
        check("lat_keys_n1", 32'(bus.keyboard_keys), 32'h0);
        wait_cyc(1);
        check("lat_bv_n2",   32'(bus.byte_valid),    32'h0);
        check("lat_keys_n2", 32'(bus.keyboard_keys), 32'h1);
        release_line();
        check("lat_nbytes",  32'(got_q.size()),      32'd2);
        if (got_q.size() == 2) begin
            check("lat_byte0", 32'(got_q[0]), 32'hE0);
            check("lat_byte1", 32'(got_q[1]), 32'h75);
        end
        send(8'hE0, 2'd0); send(8'hF0, 2'd0); send(8'h75, 2'd0);
        check("rel_up_keys", 32'(bus.keyboard_keys), 32'h0);

        // ---------------- timeout drops a partial frame ----------------
        got_q.delete(); err_seen = 0;
        drive_bits(make_frame(8'hE0, 2'd0), 5);
        wait_cyc(H);
        bus.ps2_clk = 1'b1;
        wait_cyc(TO + 10);
        check("to_no_bv", 32'(got_q.size()), 32'd0);
        check("to_no_fe", 32'(err_seen),     32'd0);
        send(8'hE0, 2'd0); send(8'h72, 2'd0);
        check("to_after_keys", 32'(bus.keyboard_keys), 32'h2);
        check("to_after_err",  32'(err_seen),          32'd0);

        // ---------------- reset mid E0 F0 72 ----------------
        send(8'hE0, 2'd0); send(8'hF0, 2'd0);
        drive_bits(make_frame(8'h72, 2'd0), 5);
        reset = 1'b1;
        #1;
        check("midrst_keys", 32'(bus.keyboard_keys), 32'h0);
        check("midrst_scan", 32'(bus.scan_byte),     32'h0);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(5);
        send(8'hE0, 2'd0); send(8'h6B, 2'd0);
        check("postrst_keys", 32'(bus.keyboard_keys), 32'h8);

        // ---------------- vector table ----------------
        do_reset();
        add(8'hE0,0,4'h0); add(8'h75,0,4'h1);
        add(8'hE0,0,4'h1); add(8'hF0,0,4'h1); add(8'h75,0,4'h0);
        add(8'hE0,0,4'h0); add(8'h75,0,4'h1);
        add(8'hE0,0,4'h1); add(8'h75,0,4'h1);
        add(8'hE0,0,4'h1); add(8'h75,0,4'h1);
        add(8'hE0,0,4'h1); add(8'h74,0,4'h5);
        add(8'hE0,0,4'h5); add(8'hF0,0,4'h5); add(8'h75,0,4'h4);
        add(8'hE0,0,4'h4); add(8'hF0,0,4'h4); add(8'h6B,0,4'h4);
        add(8'hE0,0,4'h4); add(8'h75,1,4'h4); add(8'h75,0,4'h4);
        add(8'h75,0,4'h4); add(8'hF0,0,4'h4); add(8'h75,0,4'h4);
        add(8'hE0,0,4'h4); add(8'h12,0,4'h4);
        add(8'hE0,0,4'h4); add(8'h72,2,4'h4); add(8'h72,0,4'h4);
        add(8'hE0,0,4'h4); add(8'h72,3,4'h4); add(8'h72,0,4'h4);
        add(8'hE0,0,4'h4); add(8'hF0,1,4'h4); add(8'h74,0,4'h4);
        add(8'hE0,0,4'h4); add(8'hF0,0,4'h4); add(8'h74,0,4'h0);
        add(8'hE0,0,4'h0); add(8'h6B,0,4'h8);
        add(8'hAA,0,4'h8); add(8'hE0,0,4'h8); add(8'hF0,0,4'h8); add(8'h6B,0,4'h0);
        last_good = 8'h00;
        for (int i = 0; i < tbl.size(); i++) begin
            got_q.delete(); err_seen = 0;
            send(tbl[i].dat, tbl[i].fault);
            if (tbl[i].fault == 2'd0) last_good = tbl[i].dat;
            check($sformatf("tbl%0d_keys", i), 32'(bus.keyboard_keys), 32'(tbl[i].keys));
            check($sformatf("tbl%0d_scan", i), 32'(bus.scan_byte),     32'(last_good));
            check($sformatf("tbl%0d_nbv", i),  32'(got_q.size()),      32'(tbl[i].fault == 2'd0));
            check($sformatf("tbl%0d_nfe", i),  32'(err_seen),          32'(tbl[i].fault != 2'd0));
        end

        // ---------------- randomized frames vs reference model ----------------
        do_reset();
        mkeys = 4'h0;
        pq.delete();
        last_good = 8'h00;
        for (int n = 0; n < 100; n++) begin
            logic [7:0] b;
            logic [1:0] f;
            b = pool[$urandom_range(0, 10)];
            f = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            got_q.delete(); err_seen = 0;
            send(b, f);
            if (f == 2'd0) begin
                model_byte(b);
                last_good = b;
            end else begin
                pq.delete();
            end
            check($sformatf("rnd%0d_keys", n), 32'(bus.keyboard_keys), 32'(mkeys));
            check($sformatf("rnd%0d_scan", n), 32'(bus.scan_byte),     32'(last_good));
            check($sformatf("rnd%0d_nbv", n),  32'(got_q.size()),      32'(f == 2'd0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #3000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
